snake_dir_ctrl: RTL

Producer end of the snake-movement interface. Turns raw board buttons into the movement command consumed by block_controller:
- a one-cycle move tick, which replaces the ad-hoc slow clock;
- a one-hot up/down/left/right heading, held stable between ticks.

The block debounces the buttons, rejects 180-degree reversals, and runs an IDLE/RUN/PAUSE game-state machine. It sits between the top-level button pins and block_controller, on the master clock.

---
 rtl/snake_pkg.sv | 35 +++
 rtl/btn_debounce.sv | 55 +++++
 rtl/snake_dir_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// snake_pkg
// Shared encodings for the snake game: movement directions, game states,
// the opposite-direction helper used by the reversal filter, and the
// board size shared with block_controller.
package snake_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } game_state_t;

    localparam int GRID_SIZE = 15;

    function automatic dir_t opposite(input dir_t d);
        dir_t o;
        case (d)
            DIR_UP:    o = DIR_DOWN;
            DIR_DOWN:  o = DIR_UP;
            DIR_LEFT:  o = DIR_RIGHT;
            DIR_RIGHT: o = DIR_LEFT;
            default:   o = DIR_NONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Synchronises one raw button into clk and debounces it.
// Ports:
//   clk, rst_n : master clock, async active-low reset
//   btn        : raw asynchronous button
//   level      : debounced button level
//   rise       : one-cycle press event, high in the cycle the level is
//                about to flip from 0 to 1
module btn_debounce
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise
);

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;
    logic             at_limit;

    assign at_limit = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            meta <= btn;
            sync <= meta;
            if (sync != level) begin
                if (at_limit) begin
                    level <= sync;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // Decoded from registers only, so the event lines up with the cycle the
    // level flips and the FSM acts on the same edge that updates the level.
    assign rise = sync & ~level & at_limit;

endmodule

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl
// Turns raw board buttons into the movement command for block_controller:
// a one-cycle move tick and a one-hot heading that only changes on a tick.
// Ports:
//   clk, rst_n                     : master clock, async active-low reset
//   btn_up/down/left/right         : raw direction buttons
//   btn_center                     : raw start/pause button
//   move_tick                      : one-cycle pulse per game step
//   up/down/left/right             : one-hot heading, nonzero only in RUN
//   game_state                     : 0 IDLE, 1 RUN, 2 PAUSE
//
// state | meaning
// IDLE  | waiting for the first direction press, counter held at 0
// RUN   | ticking every TICK_CYCLES, accepting non-reversing directions
// PAUSE | counter frozen, outputs blanked, directions ignored
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_CYCLES     = 25_000_000,
    parameter int CNT_W           = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_center,
    output logic       move_tick,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic [1:0] game_state
);

    logic [4:0] btn_raw;
    logic [4:0] btn_rise;
    logic [4:0] levels_unused;

    assign btn_raw = {btn_center, btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .btn  (btn_raw[i]),
            .level(levels_unused[i]),
            .rise (btn_rise[i])
        );
    end

    logic center_rise;
    assign center_rise = btn_rise[4];

    game_state_t      state, state_nxt;
    dir_t             heading, heading_nxt;
    dir_t             pending, pending_nxt;
    dir_t             out_dir, out_dir_nxt;
    logic [CNT_W-1:0] tick_cnt, tick_nxt;
    logic             tick_q, tick_q_nxt;
    dir_t             dir_evt;
    logic             dir_ok;
    logic             wrap;

    always_comb begin
        dir_evt = DIR_NONE;
        if (btn_rise[3])      dir_evt = DIR_RIGHT;
        else if (btn_rise[2]) dir_evt = DIR_LEFT;
        else if (btn_rise[0]) dir_evt = DIR_UP;
        else if (btn_rise[1]) dir_evt = DIR_DOWN;
    end

    // Reversals are judged against the committed heading, so a queued turn
    // cannot be used to sneak a 180-degree turn through in two presses.
    assign dir_ok = (dir_evt != DIR_NONE) && (dir_evt != opposite(heading));
    assign wrap   = (tick_cnt == CNT_W'(TICK_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        heading_nxt = heading;
        pending_nxt = pending;
        out_dir_nxt = out_dir;
        tick_nxt    = tick_cnt;
        tick_q_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                tick_nxt    = '0;
                out_dir_nxt = DIR_NONE;
                if (dir_ok) begin
                    pending_nxt = dir_evt;
                    heading_nxt = dir_evt;
                    state_nxt   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (center_rise) begin
                    state_nxt = ST_PAUSE;
                    // A wrap due in this cycle is deferred: the counter stays
                    // at its last count and wraps on the first cycle after resume.
                    if (!wrap) tick_nxt = tick_cnt + CNT_W'(1);
                end else begin
                    if (dir_ok) pending_nxt = dir_evt;
                    if (wrap) begin
                        tick_nxt    = '0;
                        heading_nxt = pending_nxt;
                        out_dir_nxt = pending_nxt;
                        tick_q_nxt  = 1'b1;
                    end else begin
                        tick_nxt = tick_cnt + CNT_W'(1);
                    end
                end
            end
            ST_PAUSE: begin
                if (center_rise) state_nxt = ST_RUN;
            end
            default: begin
                state_nxt   = ST_IDLE;
                tick_nxt    = '0;
                out_dir_nxt = DIR_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            heading  <= DIR_NONE;
            pending  <= DIR_NONE;
            out_dir  <= DIR_NONE;
            tick_cnt <= '0;
            tick_q   <= 1'b0;
        end else begin
            heading  <= heading_nxt;
            pending  <= pending_nxt;
            out_dir  <= out_dir_nxt;
            tick_cnt <= tick_nxt;
            tick_q   <= tick_q_nxt;
        end
    end

    // Gated by the state register so reset and PAUSE blank the outputs
    // without waiting for a clock edge.
    assign move_tick  = tick_q;
    assign up         = (state == ST_RUN) && (out_dir == DIR_UP);
    assign down       = (state == ST_RUN) && (out_dir == DIR_DOWN);
    assign left       = (state == ST_RUN) && (out_dir == DIR_LEFT);
    assign right      = (state == ST_RUN) && (out_dir == DIR_RIGHT);
    assign game_state = state;

endmodule
